// File: rtl/ex_muldiv_pkg.sv
// Shared defines for the EX-stage multiply/divide unit: RV32M op encodings,
// FSM state encoding and small op-decode helpers.
package ex_muldiv_pkg;

    localparam logic [2:0] OptMUL    = 3'd0;
    localparam logic [2:0] OptMULH   = 3'd1;
    localparam logic [2:0] OptMULHSU = 3'd2;
    localparam logic [2:0] OptMULHU  = 3'd3;
    localparam logic [2:0] OptDIV    = 3'd4;
    localparam logic [2:0] OptDIVU   = 3'd5;
    localparam logic [2:0] OptREM    = 3'd6;
    localparam logic [2:0] OptREMU   = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } muldiv_state_e;

    function automatic logic is_div_op(input logic [2:0] op);
        return op[2];
    endfunction

    function automatic logic is_rem_op(input logic [2:0] op);
        return op[2] & op[1];
    endfunction

    // MUL is treated as unsigned: its low half is identical either way.
    function automatic logic op_signed_a(input logic [2:0] op);
        return (op == OptMULH) || (op == OptMULHSU) || (op == OptDIV) || (op == OptREM);
    endfunction

    function automatic logic op_signed_b(input logic [2:0] op);
        return (op == OptMULH) || (op == OptDIV) || (op == OptREM);
    endfunction

endpackage

// File: rtl/ex_muldiv_core.sv
// Iterative unsigned datapath: one shift-add multiply or restoring divide bit
// per step. Product = {o_hi, o_lo}; for divide o_lo = quotient, o_hi = remainder.
module muldiv_core #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_load,
    input  logic            i_step,
    input  logic            i_is_div,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic [XLEN-1:0] o_hi,
    output logic [XLEN-1:0] o_lo
);

    logic [XLEN-1:0] r_hi;
    logic [XLEN-1:0] r_lo;
    logic [XLEN-1:0] r_b;
    logic            r_div;

    logic [XLEN:0]   w_sum;
    logic [XLEN:0]   w_shift;
    logic [XLEN-1:0] w_diff;
    logic            w_fits;

    assign w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : {(XLEN+1){1'b0}});
    assign w_shift = {r_hi, r_lo[XLEN-1]};
    // When the divisor fits, the true difference is below 2^XLEN, so the
    // modulo-2^XLEN subtraction of the low bits is exact.
    assign w_fits  = (w_shift >= {1'b0, r_b});
    assign w_diff  = w_shift[XLEN-1:0] - r_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi  <= '0;
            r_lo  <= '0;
            r_b   <= '0;
            r_div <= 1'b0;
        end else if (i_load) begin
            r_hi  <= '0;
            r_lo  <= i_a;
            r_b   <= i_b;
            r_div <= i_is_div;
        end else if (i_step) begin
            if (r_div) begin
                r_hi <= w_fits ? w_diff : w_shift[XLEN-1:0];
                r_lo <= {r_lo[XLEN-2:0], w_fits};
            end else begin
                r_hi <= w_sum[XLEN:1];
                r_lo <= {w_sum[0], r_lo[XLEN-1:1]};
            end
        end
    end

    assign o_hi = r_hi;
    assign o_lo = r_lo;

endmodule

// File: rtl/ex_muldiv.sv
// RV32M multiply/divide unit: control FSM, operand sign handling, special-case
// divide results; the bit-serial datapath lives in muldiv_core.
//   state   | meaning
//   ST_IDLE | ready for a new op (in_ready=1)
//   ST_CALC | one datapath bit per rdy cycle, counter 0..XLEN-1
//   ST_DONE | result on alu_o/waddr_o until out_ready
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int REG_ADDR_W   = 5,
    parameter int FAST_SPECIAL = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rdy,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            op_i,
    input  logic [XLEN-1:0]       rdata1_i,
    input  logic [XLEN-1:0]       rdata2_i,
    input  logic [REG_ADDR_W-1:0] waddr_i,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [XLEN-1:0]       alu_o,
    output logic [REG_ADDR_W-1:0] waddr_o,
    output logic                  we_o
);

    localparam int CNT_W = $clog2(XLEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    muldiv_state_e         r_state;
    muldiv_state_e         w_state_nxt;
    logic [CNT_W-1:0]      r_cnt;
    logic [2:0]            r_op;
    logic                  r_neg;
    logic                  r_special;
    logic [XLEN-1:0]       r_spec_val;
    logic [REG_ADDR_W-1:0] r_waddr;

    logic                  w_accept;
    logic                  w_step;
    logic                  w_flush;
    logic                  w_div;
    logic                  w_neg_a;
    logic                  w_neg_b;
    logic [XLEN-1:0]       w_mag_a;
    logic [XLEN-1:0]       w_mag_b;
    logic                  w_b_zero;
    logic                  w_ovf;
    logic                  w_in_special;
    logic [XLEN-1:0]       w_spec_val;
    logic                  w_neg_res;

    logic [XLEN-1:0]       w_core_hi;
    logic [XLEN-1:0]       w_core_lo;
    logic [2*XLEN-1:0]     w_prod;
    logic [2*XLEN-1:0]     w_prod_fix;
    logic [XLEN-1:0]       w_quot;
    logic [XLEN-1:0]       w_rem;
    logic [XLEN-1:0]       w_result;

    assign w_div    = is_div_op(op_i);
    assign w_neg_a  = op_signed_a(op_i) & rdata1_i[XLEN-1];
    assign w_neg_b  = op_signed_b(op_i) & rdata2_i[XLEN-1];
    assign w_mag_a  = w_neg_a ? -rdata1_i : rdata1_i;
    assign w_mag_b  = w_neg_b ? -rdata2_i : rdata2_i;
    assign w_b_zero = (rdata2_i == '0);
    assign w_ovf    = op_signed_a(op_i) & (rdata1_i == INT_MIN) & (&rdata2_i);

    assign w_in_special = w_div & (w_b_zero | w_ovf);
    assign w_spec_val   = is_rem_op(op_i) ? (w_b_zero ? rdata1_i : '0)
                                          : (w_b_zero ? '1 : rdata1_i);
    // Remainder follows the dividend sign; product and quotient follow sign XOR.
    assign w_neg_res    = is_rem_op(op_i) ? w_neg_a : (w_neg_a ^ w_neg_b);

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_step      = 1'b0;
        w_flush     = 1'b0;
        if (rdy) begin
            if (flush) begin
                w_flush     = 1'b1;
                w_state_nxt = ST_IDLE;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (in_valid) begin
                            w_accept    = 1'b1;
                            w_state_nxt = (w_in_special && (FAST_SPECIAL != 0)) ? ST_DONE : ST_CALC;
                        end
                    end
                    ST_CALC: begin
                        w_step = 1'b1;
                        if (r_cnt == CNT_LAST) begin
                            w_state_nxt = ST_DONE;
                        end
                    end
                    ST_DONE: begin
                        if (out_ready) begin
                            w_state_nxt = ST_IDLE;
                        end
                    end
                    default: w_state_nxt = ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_op       <= OptMUL;
            r_neg      <= 1'b0;
            r_special  <= 1'b0;
            r_spec_val <= '0;
            r_waddr    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_flush || w_accept) begin
                r_cnt <= '0;
            end else if (w_step) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_accept) begin
                r_op       <= op_i;
                r_neg      <= w_neg_res;
                r_special  <= w_in_special;
                r_spec_val <= w_spec_val;
                r_waddr    <= waddr_i;
            end
        end
    end

    muldiv_core #(
        .XLEN (XLEN)
    ) u_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_load   (w_accept),
        .i_step   (w_step),
        .i_is_div (w_div),
        .i_a      (w_mag_a),
        .i_b      (w_mag_b),
        .o_hi     (w_core_hi),
        .o_lo     (w_core_lo)
    );

    assign w_prod     = {w_core_hi, w_core_lo};
    assign w_prod_fix = r_neg ? -w_prod : w_prod;
    assign w_quot     = r_neg ? -w_core_lo : w_core_lo;
    assign w_rem      = r_neg ? -w_core_hi : w_core_hi;

    always_comb begin
        w_result = '0;
        case (r_op)
            OptMUL:                       w_result = w_prod_fix[XLEN-1:0];
            OptMULH, OptMULHSU, OptMULHU: w_result = w_prod_fix[2*XLEN-1:XLEN];
            OptDIV, OptDIVU:              w_result = w_quot;
            default:                      w_result = w_rem;
        endcase
        if (r_special) begin
            w_result = r_spec_val;
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign alu_o     = out_valid ? w_result : '0;
    assign waddr_o   = out_valid ? r_waddr : '0;
    assign we_o      = out_valid & (r_waddr != '0);

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: a reference model fills a scoreboard on
// every accepted op; a negedge monitor checks result, destination and latency.
module tb_ex_muldiv;

    localparam int XLEN   = 32;
    localparam int LAT    = XLEN + 1;
    localparam int TMO    = 300;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rdy;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op_i;
    logic [31:0] rdata1_i;
    logic [31:0] rdata2_i;
    logic [4:0]  waddr_i;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] alu_o;
    logic [4:0]  waddr_o;
    logic        we_o;

    ex_muldiv #(
        .XLEN         (XLEN),
        .REG_ADDR_W   (5),
        .FAST_SPECIAL (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rdy       (rdy),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_i      (op_i),
        .rdata1_i  (rdata1_i),
        .rdata2_i  (rdata2_i),
        .waddr_i   (waddr_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .alu_o     (alu_o),
        .waddr_o   (waddr_o),
        .we_o      (we_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] alu;
        logic [4:0]  wa;
        int          acc;
        int          lat;
    } exp_t;

    exp_t sb[$];
    exp_t head;
    int   cyc        = 0;
    int   head_stall = 0;
    bit   head_seen  = 0;
    int   n_checks   = 0;
    int   n_errors   = 0;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0]        ax_s, bx_s, ax_u, bx_u, p;
        logic signed [31:0] sa, sb_v;
        logic [31:0]        r;
        ax_s = {{32{a[31]}}, a};
        bx_s = {{32{b[31]}}, b};
        ax_u = {32'h0, a};
        bx_u = {32'h0, b};
        sa   = a;
        sb_v = b;
        r    = '0;
        p    = '0;
        case (op)
            3'd0: begin p = ax_u * bx_u; r = p[31:0];  end
            3'd1: begin p = ax_s * bx_s; r = p[63:32]; end
            3'd2: begin p = ax_s * bx_u; r = p[63:32]; end
            3'd3: begin p = ax_u * bx_u; r = p[63:32]; end
            3'd4: begin
                if (b == 32'h0) r = 32'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
                else r = sa / sb_v;
            end
            3'd5: r = (b == 32'h0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 32'h0) r = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h0;
                else r = sa % sb_v;
            end
            default: r = (b == 32'h0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic bit is_special(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        return op[2] && ((b == 32'h0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            sb.delete();
            head_seen  = 0;
            head_stall = 0;
        end else begin
            if (sb.size() == 0) begin
                check_val("no_spurious_valid", 64'(out_valid), 64'(0));
            end else begin
                head = sb[0];
                if (out_valid) begin
                    if (!head_seen) begin
                        check_val("latency", 64'(cyc - head.acc), 64'(head.lat + head_stall));
                        head_seen = 1;
                    end
                    check_val("alu_o", 64'(alu_o), 64'(head.alu));
                    check_val("waddr_o", 64'(waddr_o), 64'(head.wa));
                    check_val("we_o", 64'(we_o), 64'(head.wa != 5'd0));
                    check_val("in_ready_busy", 64'(in_ready), 64'(0));
                    if (out_ready && rdy) begin
                        void'(sb.pop_front());
                        head_seen  = 0;
                        head_stall = 0;
                    end
                end else if (!rdy) begin
                    head_stall++;
                end
                if (flush && rdy) begin
                    sb.delete();
                    head_seen  = 0;
                    head_stall = 0;
                end
            end
            if (in_valid && in_ready && rdy && !flush) begin
                sb.push_back('{alu: model(op_i, rdata1_i, rdata2_i), wa: waddr_i, acc: cyc,
                               lat: is_special(op_i, rdata1_i, rdata2_i) ? 1 : LAT});
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] wa);
        int n = 0;
        while (!in_ready && n < TMO) begin
            step(1);
            n++;
        end
        if (n >= TMO) check_val("ready_timeout", 64'(in_ready), 64'(1));
        in_valid = 1'b1;
        op_i     = op;
        rdata1_i = a;
        rdata2_i = b;
        waddr_i  = wa;
        step(1);
        in_valid = 1'b0;
        op_i     = 3'($urandom_range(0, 7));
        rdata1_i = $urandom;
        rdata2_i = $urandom;
        waddr_i  = 5'($urandom_range(0, 31));
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < TMO) begin
            step(1);
            n++;
        end
        if (n >= TMO) check_val("drain_timeout", 64'(sb.size()), 64'(0));
    endtask

    logic [2:0]  t_op [12] = '{3'd0, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd6, 3'd4, 3'd1, 3'd7, 3'd4, 3'd0};
    logic [31:0] t_a  [12] = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100,
                               32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'd1000, 32'hFFFF_FF00, 32'd123};
    logic [31:0] t_b  [12] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd2, 32'd0,
                               32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'd7, 32'd0, 32'd456};

    initial begin
        rst_n     = 1'b0;
        rdy       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        op_i      = 3'd0;
        rdata1_i  = '0;
        rdata2_i  = '0;
        waddr_i   = '0;
        out_ready = 1'b1;
        step(3);
        check_val("rst_out_valid", 64'(out_valid), 64'(0));
        check_val("rst_alu_o", 64'(alu_o), 64'(0));
        check_val("rst_waddr_o", 64'(waddr_o), 64'(0));
        check_val("rst_we_o", 64'(we_o), 64'(0));
        rst_n = 1'b1;
        step(1);
        check_val("rst_in_ready", 64'(in_ready), 64'(1));

        for (int i = 0; i < 12; i++) begin
            issue(t_op[i], t_a[i], t_b[i], (i == 11) ? 5'd0 : 5'(i + 1));
        end
        drain();

        for (int i = 0; i < 16; i++) begin
            issue(3'($urandom_range(0, 7)), $urandom,
                  ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 5)) : $urandom,
                  5'($urandom_range(0, 31)));
        end
        drain();

        issue(3'd5, 32'd1000, 32'd7, 5'd3);
        step(9);
        flush = 1'b1;
        step(1);
        flush = 1'b0;
        check_val("in_ready_after_flush", 64'(in_ready), 64'(1));
        check_val("valid_after_flush", 64'(out_valid), 64'(0));
        step(40);
        issue(3'd5, 32'd1000, 32'd7, 5'd4);
        drain();

        out_ready = 1'b0;
        issue(3'd0, 32'd12345, 32'd678, 5'd9);
        step(5);
        rdy = 1'b0;
        step(2);
        rdy = 1'b1;
        step(3);
        rdy = 1'b0;
        step(1);
        rdy = 1'b1;
        begin
            int n = 0;
            while (!out_valid && n < TMO) begin
                step(1);
                n++;
            end
            if (n >= TMO) check_val("stall_valid_timeout", 64'(out_valid), 64'(1));
        end
        step(5);
        out_ready = 1'b1;
        drain();

        issue(3'd4, 32'hFFFF_F000, 32'd17, 5'd12);
        step(8);
        rst_n = 1'b0;
        #1;
        check_val("rst_mid_calc_valid", 64'(out_valid), 64'(0));
        check_val("rst_mid_calc_ready", 64'(in_ready), 64'(1));
        step(2);
        rst_n = 1'b1;
        step(40);
        issue(3'd6, 32'hFFFF_F000, 32'd17, 5'd13);
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_errors, n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
